// File: rtl/store_data_packer.sv
// ============================================================================
// Module      : store_data_packer
// Description : MEM-stage store path. Packs SB/SH/SW stores into big-endian
//               word writes and queues them toward data memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_data_packer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    input  logic [1:0]    st_size,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic          misalign_err,
    input  logic [31:0]   ld_addr,
    output logic          ld_hit,
    output logic [CW-1:0] count
);

    localparam int          c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] c_full = CW'(DEPTH);

    logic [29:0]        addr_mem  [DEPTH];
    logic [31:0]        wdata_mem [DEPTH];
    logic [3:0]         be_mem    [DEPTH];

    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               misalign_err_q, misalign_err_d;

    logic               illegal;
    logic               push;
    logic               pop;
    logic [31:0]        pack_wdata;
    logic [3:0]         pack_be;

    // Word-granular comparisons never look at the byte offset of the load.
    logic               unused_ld_offset;
    assign unused_ld_offset = ^ld_addr[1:0];

    always_comb begin
        illegal    = 1'b0;
        pack_wdata = st_data;
        pack_be    = 4'b1111;
        case (st_size)
            2'b00: begin
                pack_wdata = {4{st_data[7:0]}};
                pack_be    = 4'b1000 >> st_addr[1:0];
            end
            2'b01: begin
                illegal    = st_addr[0];
                pack_wdata = {2{st_data[15:0]}};
                pack_be    = st_addr[1] ? 4'b0011 : 4'b1100;
            end
            2'b10: begin
                illegal    = |st_addr[1:0];
            end
            default: begin
                illegal    = 1'b1;
            end
        endcase
    end

    always_comb begin
        st_ready       = (count_q != c_full);
        mem_valid      = (count_q != '0);
        push           = st_valid & st_ready & ~illegal;
        pop            = mem_valid & mem_ready;
        misalign_err_d = st_valid & st_ready & illegal;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    // Payload storage needs no reset; validity comes only from the pointers.
    always_ff @(posedge Clk) begin
        if (push) begin
            addr_mem[wr_ptr_q]  <= st_addr[31:2];
            wdata_mem[wr_ptr_q] <= pack_wdata;
            be_mem[wr_ptr_q]    <= pack_be;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (mem_valid) begin
            mem_addr  = {addr_mem[rd_ptr_q], 2'b00};
            mem_wdata = wdata_mem[rd_ptr_q];
            mem_be    = be_mem[rd_ptr_q];
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(c_ptr_w'(c_ptr_w'(i) - rd_ptr_q)) < count_q) &&
                (addr_mem[i] == ld_addr[31:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

    assign count        = count_q;
    assign misalign_err = misalign_err_q;

endmodule

`default_nettype wire
